// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding a 4-digit display.
// Digits update only on completion; values above 9999 saturate to 9999 with ovf.
module bin_to_bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       bcd0,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd3
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] sr_q, sr_d;
    logic [15:0]      acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [15:0]      dig_q, dig_d;
    logic             ovf_q, ovf_d;

    logic [15:0]      acc_adj;
    logic [15:0]      acc_shl;
    logic             bin_big;
    logic             last_shift;

    assign bin_big    = 32'(bin) > 32'd9999;
    assign last_shift = cnt_q == 4'(BIN_W - 1);

    // All nibbles corrected in parallel from the start-of-cycle value.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_shl = {acc_adj[14:0], sr_q[BIN_W-1]};
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        dig_d      = dig_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (start) begin
                    sr_d       = bin;
                    acc_d      = 16'h0;
                    cnt_d      = 4'd0;
                    ovf_pend_d = bin_big;
                    state_d    = S_SHIFT;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_SHIFT: begin
                acc_d = acc_shl;
                sr_d  = {sr_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                // Digits load from the post-shift value on the edge entering FINISH.
                if (last_shift) begin
                    state_d = S_FINISH;
                    dig_d   = ovf_pend_q ? 16'h9999 : acc_shl;
                    ovf_d   = ovf_pend_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            acc_q      <= 16'h0;
            cnt_q      <= 4'd0;
            ovf_pend_q <= 1'b0;
            dig_q      <= 16'h0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            dig_q      <= dig_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy = state_q == S_SHIFT;
    assign done = state_q == S_FINISH;
    assign ovf  = ovf_q;
    assign bcd0 = dig_q[3:0];
    assign bcd1 = dig_q[7:4];
    assign bcd2 = dig_q[11:8];
    assign bcd3 = dig_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: directed vectors, monitor pops on done.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  bcd0;
    logic [3:0]  bcd1;
    logic [3:0]  bcd2;
    logic [3:0]  bcd3;

    int checks = 0;
    int errors = 0;
    int ndone  = 0;
    logic [16:0] exp_q[$];
    logic        prev_done = 1'b0;

    bin_to_bcd_seq #(.BIN_W(14)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .bcd0  (bcd0),
        .bcd1  (bcd1),
        .bcd2  (bcd2),
        .bcd3  (bcd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] outs();
        return {ovf, bcd3, bcd2, bcd1, bcd0};
    endfunction

    // Monitor: compares every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (done) begin
            ndone++;
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_twice: done high two cycles in a row");
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got %h with empty scoreboard",
                         outs());
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if (outs() !== e) begin
                    errors++;
                    $display("FAIL result: got %h expected %h", outs(), e);
                end
            end
        end
        prev_done <= done;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 40);
        if (!done) begin
            errors++;
            $display("FAIL timeout: no done within %0d cycles", n);
        end
    endtask

    task automatic conv(input logic [13:0] v, input logic [16:0] e);
        int n;
        bin   = v;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done(n);
        chk("latency", n, 32'd14);
        chk("busy_in_finish", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int n2;
        rst   = 1'b1;
        start = 1'b0;
        bin   = 14'd0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outs", 32'(outs()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        conv(14'd1234, 17'h01234);
        // Outputs hold while bin wanders without start.
        for (int i = 0; i < 5; i++) begin
            bin = 14'(i * 977);
            @(posedge clk);
            #1;
        end
        chk("hold_1234", 32'(outs()), 32'h01234);

        conv(14'd0,     17'h00000);
        conv(14'd9999,  17'h09999);
        conv(14'd10000, 17'h19999);
        conv(14'd16383, 17'h19999);
        conv(14'd42,    17'h00042);
        chk("ovf_cleared", 32'(ovf), 32'd0);

        // Start during busy is ignored.
        bin   = 14'd5678;
        start = 1'b1;
        exp_q.push_back(17'h05678);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bin   = 14'd1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 14'd0;
        wait_done(n2);
        chk("ignored_start_latency", 32'(5 + n2), 32'd14);
        repeat (25) @(posedge clk);
        #1;
        chk("single_done", 32'(done), 32'd0);
        chk("hold_5678", 32'(outs()), 32'h05678);

        // Back-to-back conversions with start held high.
        bin   = 14'h0FFF;
        start = 1'b1;
        repeat (3) exp_q.push_back(17'h04095);
        @(posedge clk);
        #1;
        wait_done(n);
        chk("b2b_first", n, 32'd14);
        wait_done(n);
        chk("b2b_period2", n, 32'd15);
        wait_done(n);
        chk("b2b_period3", n, 32'd15);
        repeat (7) @(posedge clk);
        #1;
        chk("busy_cycle7", 32'(busy), 32'd1);
        start = 1'b0;
        rst   = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_outs", 32'(outs()), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("no_done_after_rst", 32'(outs()), 32'd0);

        conv(14'h0FFF, 17'h04095);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("done_count", ndone, 32'd11);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Converts an unsigned binary count of up to 14 bits into four BCD digits.
- Sits directly upstream of the 4-digit seven-segment scan driver and feeds its bcd0..bcd3 inputs.
- Digit outputs are registered and change only when a conversion completes, so the display never shows partial results.

Parameters:
- BIN_W, 14, width of the binary input. Legal range 4..14.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled on the rising clk edge.
- bin  input  BIN_W  unsigned binary value; sampled only on the edge where start is accepted.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse marking that the outputs have just updated.
- ovf  output  1  value of the last accepted bin exceeded 9999; held until the next completion.
- bcd0  output  4  ones digit (least significant, rightmost display digit).
- bcd1  output  4  tens digit.
- bcd2  output  4  hundreds digit.
- bcd3  output  4  thousands digit.

Behaviour:
- Reset (rst=1, asynchronous):
  - State goes to IDLE.
  - busy, done and ovf are 0; bcd0..bcd3 are 4'h0.
  - Internal shift register, digit accumulator and counter are cleared.
  - Reset mid-conversion aborts it with no done pulse. Outputs return to 0, not to the previous result.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - A start sampled high captures bin into the shift register and clears the 16-bit accumulator and the counter.
  - It also computes ovf_pend = (bin > 9999), then moves to SHIFT.
  - busy goes high on that same edge.
- SHIFT:
  - Each cycle, any accumulator nibble >= 5 first has 3 added. All nibbles are corrected in parallel, from the value at the start of the cycle.
  - The {accumulator, shift register} concatenation then shifts left by 1, and the counter increments.
  - After exactly BIN_W SHIFT cycles, the state moves to FINISH.
- FINISH (one cycle):
  - On the edge entering FINISH, bcd3..bcd0 load the accumulator nibbles (bcd3 = [15:12] ... bcd0 = [3:0]).
  - If ovf_pend is set, all four digits load 4'h9 instead and ovf loads ovf_pend.
  - done=1 and busy=0 for this cycle. The next state is IDLE.
- Latency: start accepted at edge E gives busy=1 for cycles E+1..E+BIN_W, with done=1 in cycle E+BIN_W+1. For BIN_W=14 that is done 15 cycles after the accepting edge.
- Start handling:
  - start while busy=1 (SHIFT) is ignored; no queueing, and the captured bin is unaffected.
  - start in the FINISH cycle is accepted, which allows back-to-back conversions with one done per conversion.
- Width rules:
  - bin is treated as unsigned and zero-extended internally.
  - For BIN_W <= 13, ovf can never assert.
  - Add-3 correction applies to all four nibbles including bcd3; no fifth digit exists.
- Output stability: bcd0..bcd3 and ovf hold their values between done pulses regardless of start or bin activity.
- done is never asserted for two consecutive cycles.

Test Plan:
- rst pulse mid-stream -> all outputs 0 immediately (before the next clk edge); busy=0; no done follows.
- bin=1234, start for 1 cycle -> busy for 14 cycles, then done pulse with bcd3..0 = 1,2,3,4 and ovf=0; outputs hold afterwards.
- bin=0, then bin=9999 -> first done gives 0,0,0,0; second gives 9,9,9,9 with ovf=0.
- bin=10000, then bin=16383 -> both give digits 9,9,9,9 with ovf=1. A following bin=42 -> 0,0,4,2 and ovf clears to 0.
- Start with bin=5678, then raise start with bin=1111 on cycle 5 of busy -> single done with 5,6,7,8; no second conversion.
- Start held high continuously, bin=0x0FFF (4095) -> done every 15 cycles, each with 4,0,9,5. Assert rst at busy cycle 7 -> outputs 0, no done, and conversion restarts cleanly after rst deasserts.
